proton_regfile: RTL and testbench

Parametrised integer register file for the PROTON RV32I core, replacing the fixed 32-entry REG array. Adds a configurable number of read ports, optional write-to-read bypass, a hardware initialisation sweep after reset, and a debug port. The debug port lets benches preload and dump registers through ports instead of poking internal arrays. It sits between the decode stage (read ports) and the writeback stage (write port).

---
 rtl/proton_pkg.sv | 13 +
 rtl/proton_regfile_rdport.sv | 39 +++
 rtl/proton_regfile.sv | 138 +++++++++++++
 tb/tb_proton_regfile.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/proton_pkg.sv
// Shared definitions for the PROTON integer register file: default sizes and
// the two-state init/run encoding.
package proton_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/proton_regfile_rdport.sv
// One combinational read port: array lookup with range, hardwired-zero and
// same-cycle writeback bypass overrides, forced to zero while the sweep runs.
module proton_regfile_rdport
  import proton_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREG     = NREG_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int AW       = $clog2(NREG)
) (
  input  logic [XLEN-1:0] mem [NREG],
  input  logic [AW-1:0]   rd_addr,
  input  logic            busy,
  input  logic            we,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  output logic [XLEN-1:0] rd_data
);

  localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

  // Read mux, overrides in priority order.
  always_comb begin
    rd_data = {XLEN{1'b0}};
    if (busy) begin
      rd_data = {XLEN{1'b0}};
    end else if ({1'b0, rd_addr} >= NREG_W) begin
      rd_data = {XLEN{1'b0}};
    end else if ((ZERO_REG != 0) && (rd_addr == {AW{1'b0}})) begin
      rd_data = {XLEN{1'b0}};
    end else if ((BYPASS != 0) && we && (wr_addr == rd_addr)) begin
      rd_data = wr_data;
    end else begin
      rd_data = mem[rd_addr];
    end
  end

endmodule

// File: rtl/proton_regfile.sv
// Parametrised RV32I integer register file with init sweep, writeback bypass
// and a debug access port that yields to writeback.
module proton_regfile
  import proton_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int NREG      = NREG_DEF,
  parameter int NRD       = 2,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1,
  parameter int INIT_MODE = 0,
  localparam int AW       = $clog2(NREG)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NRD*AW-1:0]   RD_ADDR,
  output logic [NRD*XLEN-1:0] RD_DATA,
  input  logic                WE,
  input  logic [AW-1:0]       WR_ADDR,
  input  logic [XLEN-1:0]     WR_DATA,
  input  logic                DBG_REQ,
  input  logic                DBG_WE,
  input  logic [AW-1:0]       DBG_ADDR,
  input  logic [XLEN-1:0]     DBG_WDATA,
  output logic                DBG_ACK,
  output logic [XLEN-1:0]     DBG_RDATA,
  output logic                BUSY
);

  localparam logic [AW:0]   NREG_W   = (AW+1)'(NREG);
  localparam logic [AW-1:0] CNT_LAST = AW'(NREG - 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            dbg_ack_q, dbg_ack_d;
  logic [XLEN-1:0] dbg_rdata_q, dbg_rdata_d;
  logic [XLEN-1:0] mem_q [NREG];
  logic            mem_we_s;
  logic [AW-1:0]   mem_waddr_s;
  logic [XLEN-1:0] mem_wdata_s;
  logic            busy_s;

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < NREG_W);
  endfunction

  function automatic logic wr_ok(input logic [AW-1:0] a);
    return addr_ok(a) && !((ZERO_REG != 0) && (a == {AW{1'b0}}));
  endfunction

  assign busy_s = (state_q == ST_CLEAR);

  // Next-state logic; init, writeback and debug share the single write port.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dbg_ack_d   = 1'b0;
    dbg_rdata_d = {XLEN{1'b0}};
    mem_we_s    = 1'b0;
    mem_waddr_s = cnt_q;
    mem_wdata_s = (INIT_MODE != 0) ? XLEN'(cnt_q) : {XLEN{1'b0}};
    case (state_q)
      ST_CLEAR: begin
        mem_we_s = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
          cnt_d   = {AW{1'b0}};
        end else begin
          cnt_d = cnt_q + AW'(1'b1);
        end
      end
      ST_RUN: begin
        if (WE) begin
          mem_we_s    = wr_ok(WR_ADDR);
          mem_waddr_s = WR_ADDR;
          mem_wdata_s = WR_DATA;
        end else if (DBG_REQ) begin
          dbg_ack_d = 1'b1;
          if (DBG_WE) begin
            mem_we_s    = wr_ok(DBG_ADDR);
            mem_waddr_s = DBG_ADDR;
            mem_wdata_s = DBG_WDATA;
          end else begin
            dbg_rdata_d = addr_ok(DBG_ADDR) ? mem_q[DBG_ADDR] : {XLEN{1'b0}};
          end
        end else begin
          mem_we_s = 1'b0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // Control and debug-response flops.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_CLEAR;
      cnt_q       <= {AW{1'b0}};
      dbg_ack_q   <= 1'b0;
      dbg_rdata_q <= {XLEN{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dbg_ack_q   <= dbg_ack_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  // Storage array, no reset so it maps onto distributed RAM.
  always_ff @(posedge CLK) begin
    if (mem_we_s && !RST) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    proton_regfile_rdport #(
      .XLEN    (XLEN),
      .NREG    (NREG),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS),
      .AW      (AW)
    ) u_rdport (
      .mem    (mem_q),
      .rd_addr(RD_ADDR[k*AW +: AW]),
      .busy   (busy_s),
      .we     (WE),
      .wr_addr(WR_ADDR),
      .wr_data(WR_DATA),
      .rd_data(RD_DATA[k*XLEN +: XLEN])
    );
  end

  assign DBG_ACK   = dbg_ack_q;
  assign DBG_RDATA = dbg_rdata_q;
  assign BUSY      = busy_s;

endmodule

// File: tb/tb_proton_regfile.sv
// Directed bench: a default instance alongside a 24-entry, 3-port,
// no-bypass, no-zero-reg, index-initialised instance sharing the stimulus.
module tb_proton_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        dbg_req, dbg_we;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic [9:0]  rd_addr0;
  logic [14:0] rd_addr1;
  logic [63:0] rd_data0;
  logic [95:0] rd_data1;
  logic        ack0, ack1, busy0, busy1;
  logic [31:0] rdata0, rdata1;

  int passes = 0;
  int total  = 0;
  int n0, n1;

  always #5 clk = ~clk;

  proton_regfile dut0 (
    .CLK(clk), .RST(rst), .RD_ADDR(rd_addr0), .RD_DATA(rd_data0),
    .WE(we), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
    .DBG_REQ(dbg_req), .DBG_WE(dbg_we), .DBG_ADDR(dbg_addr), .DBG_WDATA(dbg_wdata),
    .DBG_ACK(ack0), .DBG_RDATA(rdata0), .BUSY(busy0)
  );

  proton_regfile #(
    .NREG(24), .NRD(3), .ZERO_REG(0), .BYPASS(0), .INIT_MODE(1)
  ) dut1 (
    .CLK(clk), .RST(rst), .RD_ADDR(rd_addr1), .RD_DATA(rd_data1),
    .WE(we), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
    .DBG_REQ(dbg_req), .DBG_WE(dbg_we), .DBG_ADDR(dbg_addr), .DBG_WDATA(dbg_wdata),
    .DBG_ACK(ack1), .DBG_RDATA(rdata1), .BUSY(busy1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One debug access; returns just after the accepting edge.
  task automatic dbg(input logic w, input logic [4:0] a, input logic [31:0] d);
    dbg_req   = 1'b1;
    dbg_we    = w;
    dbg_addr  = a;
    dbg_wdata = d;
    tick();
    dbg_req = 1'b0;
  endtask

  task automatic sweep_len();
    n0 = 0;
    n1 = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (n0 == 0 && !busy0) n0 = i;
      if (n1 == 0 && !busy1) n1 = i;
    end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 5'd0; dbg_wdata = 32'd0;
    rd_addr0 = 10'd0; rd_addr1 = 15'd0;
    tick();
    tick();
    chk("rst_busy0", busy0, 1'b1);
    chk("rst_busy1", busy1, 1'b1);
    chk("rst_ack0", ack0, 1'b0);
    chk("rst_rdata1", rdata1, 32'd0);

    rst = 1'b0;
    sweep_len();
    chk("sweep_len0", n0, 32'd32);
    chk("sweep_len1", n1, 32'd24);

    dbg(1'b0, 5'd5, 32'd0);
    chk("dbg_ack0", ack0, 1'b1);
    chk("dbg_ack1", ack1, 1'b1);
    chk("init_r5_0", rdata0, 32'd0);
    chk("init_r5_1", rdata1, 32'd5);
    tick();
    chk("ack_pulse0", ack0, 1'b0);
    dbg(1'b0, 5'd0, 32'd0);
    chk("init_r0_1", rdata1, 32'd0);
    dbg(1'b0, 5'd31, 32'd0);
    chk("init_r31_0", rdata0, 32'd0);
    chk("oor_ack1", ack1, 1'b1);
    chk("oor_r31_1", rdata1, 32'd0);

    we = 1'b1; wr_addr = 5'd1; wr_data = 32'h1E;
    rd_addr0 = {5'd4, 5'd1};
    rd_addr1 = {5'd0, 5'd4, 5'd1};
    #1;
    chk("bypass_r1_0", rd_data0[31:0], 32'h1E);
    chk("nobypass_r1_1", rd_data1[31:0], 32'd1);
    tick();
    wr_addr = 5'd4; wr_data = 32'h3;
    #1;
    chk("bypass_r4_0", rd_data0, {32'h3, 32'h1E});
    chk("nobypass_r4_1", rd_data1[63:0], {32'h4, 32'h1E});
    tick();
    we = 1'b0;
    #1;
    chk("wb_pair0", rd_data0, {32'h3, 32'h1E});
    chk("wb_pair1", rd_data1[63:0], {32'h3, 32'h1E});

    we = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEADBEEF;
    rd_addr0 = 10'd0; rd_addr1 = 15'd0;
    #1;
    chk("zero_vs_bypass0", rd_data0[31:0], 32'd0);
    tick();
    we = 1'b0;
    #1;
    chk("zero_reg0", rd_data0, 64'd0);
    chk("no_zero_reg1", rd_data1, {3{32'hDEADBEEF}});

    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd7; dbg_wdata = 32'h55;
    we = 1'b1; wr_addr = 5'd2; wr_data = 32'h22;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("arb_wait0", ack0, 1'b0);
      chk("arb_wait1", ack1, 1'b0);
    end
    we = 1'b0;
    tick();
    chk("arb_ack0", ack0, 1'b1);
    chk("arb_ack1", ack1, 1'b1);
    dbg_req = 1'b0;
    tick();
    chk("arb_single0", ack0, 1'b0);
    rd_addr0 = {5'd7, 5'd2};
    #1;
    chk("arb_data0", rd_data0, {32'h55, 32'h22});
    dbg(1'b0, 5'd7, 32'd0);
    chk("dbg_r7_0", rdata0, 32'h55);
    chk("dbg_r7_1", rdata1, 32'h55);

    dbg(1'b1, 5'd0, 32'h77);
    chk("dbgw_r0_ack0", ack0, 1'b1);
    dbg(1'b0, 5'd0, 32'd0);
    chk("dbgw_r0_0", rdata0, 32'd0);
    chk("dbgw_r0_1", rdata1, 32'h77);

    we = 1'b1; wr_addr = 5'd30; wr_data = 32'hAAAA5555;
    rd_addr1 = {5'd30, 5'd1, 5'd4};
    tick();
    we = 1'b0;
    rd_addr0 = {5'd30, 5'd30};
    #1;
    chk("oor_rd1", rd_data1[95:64], 32'd0);
    chk("r30_rd0", rd_data0[63:32], 32'hAAAA5555);
    dbg(1'b0, 5'd30, 32'd0);
    chk("oor_dbg_ack1", ack1, 1'b1);
    chk("oor_dbg_rd1", rdata1, 32'd0);
    chk("r30_dbg0", rdata0, 32'hAAAA5555);

    dbg(1'b1, 5'd3, 32'h33);
    dbg(1'b0, 5'd3, 32'd0);
    chk("preload_r3_0", rdata0, 32'h33);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd3;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("clear_noack0", ack0, 1'b0);
    end
    #1;
    chk("clear_rd0", rd_data0, 64'd0);
    chk("mid_busy0", busy0, 1'b1);
    rst = 1'b1;
    tick();
    chk("rst_drop_ack0", ack0, 1'b0);
    dbg_req = 1'b0;
    rst = 1'b0;
    sweep_len();
    chk("resweep_len0", n0, 32'd32);
    chk("resweep_len1", n1, 32'd24);
    chk("resweep_r30_0", rd_data0, 64'd0);
    dbg(1'b0, 5'd3, 32'd0);
    chk("resweep_r3_0", rdata0, 32'd0);
    chk("resweep_r3_1", rdata1, 32'd3);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
